// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target that answers one 7-bit address and maps I2C byte
// transfers onto an 8-bit register bus (pointer byte, then auto-incrementing
// data bytes). SCL is sampled only, never stretched; SDA is open-drain.
//
// Register-bus handshake: o_req_valid is a single-cycle strobe with no
// back-pressure. o_req_write, o_req_addr and o_req_wdata are valid in that
// cycle; for a read, i_resp_rdata must be valid exactly one cycle after it.
module i2c_slave_regs #(
    parameter logic [6:0]  DEV_ADDR    = 7'h74,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_sda_dir,
    output logic       o_req_valid,
    output logic       o_req_write,
    output logic [7:0] o_req_addr,
    output logic [7:0] o_req_wdata,
    input  logic [7:0] i_resp_rdata,
    output logic       o_busy,
    output logic [3:0] o_dbg_state
);

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ACK_ADDR = 4'd2,
        S_PTR      = 4'd3,
        S_ACK_PTR  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_ACK_WR   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // What SDA should do once the hold delay after an SCL fall has elapsed
    typedef enum logic [1:0] {
        DRV_REL  = 2'd0,
        DRV_ACK  = 2'd1,
        DRV_DATA = 2'd2
    } drv_t;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    // Two-flop synchronisers plus a previous-cycle copy for edge decoding
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= i_scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= i_sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  ptr_q;
    logic [7:0]  tx_q;
    logic        rw_q;
    logic        ack_q;
    logic        busy_q;
    logic        sda_rel_q;
    logic        req_valid_q;
    logic        req_write_q;
    logic [7:0]  req_addr_q;
    logic [7:0]  req_wdata_q;
    logic        rd_cap_q;
    logic        drv_pend_q;
    drv_t        drv_sel_q;
    logic [3:0]  hold_cnt_q;

    logic [7:0]  rx_byte;
    logic [7:0]  tx_cur;
    logic        rd_wait;
    logic        drv_apply;

    // Byte completed by the bit being sampled this cycle
    assign rx_byte   = {shift_q, sda_sync_q};
    // Read data arrives the cycle it is captured; bypass it so the first bit
    // can be driven in that same cycle
    assign tx_cur    = rd_cap_q ? i_resp_rdata : tx_q;
    // While a read strobe is out the response is not yet available
    assign rd_wait   = req_valid_q & ~req_write_q;
    assign drv_apply = drv_pend_q & (hold_cnt_q <= 4'd1) & ~rd_wait;

    // Protocol FSM, SDA drive scheduling and register-bus strobes
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            ptr_q       <= 8'd0;
            tx_q        <= 8'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            busy_q      <= 1'b0;
            sda_rel_q   <= 1'b1;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= 8'd0;
            req_wdata_q <= 8'd0;
            rd_cap_q    <= 1'b0;
            drv_pend_q  <= 1'b0;
            drv_sel_q   <= DRV_REL;
            hold_cnt_q  <= 4'd0;
        end else begin
            req_valid_q <= 1'b0;
            rd_cap_q    <= req_valid_q & ~req_write_q;
            if (hold_cnt_q != 4'd0) begin
                hold_cnt_q <= hold_cnt_q - 4'd1;
            end

            // Apply a pending SDA change once the hold time has elapsed
            if (drv_apply) begin
                drv_pend_q <= 1'b0;
                case (drv_sel_q)
                    DRV_ACK:  sda_rel_q <= 1'b0;
                    DRV_DATA: begin
                        sda_rel_q <= tx_cur[7];
                        tx_q      <= {tx_cur[6:0], 1'b0};
                    end
                    default:  sda_rel_q <= 1'b1;
                endcase
            end else if (rd_cap_q) begin
                tx_q <= i_resp_rdata;
            end

            if (start_det) begin
                state_q    <= S_ADDR;
                bit_cnt_q  <= 4'd0;
                drv_pend_q <= 1'b0;
                sda_rel_q  <= 1'b1;
            end else if (stop_det) begin
                state_q    <= S_IDLE;
                bit_cnt_q  <= 4'd0;
                drv_pend_q <= 1'b0;
                sda_rel_q  <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WR_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == S_ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_q <= S_ACK_ADDR;
                                        busy_q  <= 1'b1;
                                        rw_q    <= rx_byte[0];
                                    end else begin
                                        state_q <= S_IGNORE;
                                        busy_q  <= 1'b0;
                                    end
                                end else if (state_q == S_PTR) begin
                                    ptr_q   <= rx_byte;
                                    state_q <= S_ACK_PTR;
                                end else begin
                                    req_valid_q <= 1'b1;
                                    req_write_q <= 1'b1;
                                    req_addr_q  <= ptr_q;
                                    req_wdata_q <= rx_byte;
                                    ptr_q       <= ptr_q + 8'd1;
                                    state_q     <= S_ACK_WR;
                                end
                            end
                        end
                    end
                    S_ACK_ADDR, S_ACK_PTR, S_ACK_WR: begin
                        // bit_cnt 8: before the 9th clock, 9: after it
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            drv_pend_q <= 1'b1;
                            hold_cnt_q <= HOLD;
                            if (bit_cnt_q == 4'd8) begin
                                drv_sel_q <= DRV_ACK;
                            end else begin
                                bit_cnt_q <= 4'd0;
                                if (state_q == S_ACK_ADDR && rw_q) begin
                                    drv_sel_q   <= DRV_DATA;
                                    req_valid_q <= 1'b1;
                                    req_write_q <= 1'b0;
                                    req_addr_q  <= ptr_q;
                                    state_q     <= S_RD_DATA;
                                end else begin
                                    drv_sel_q <= DRV_REL;
                                    state_q   <= (state_q == S_ACK_ADDR) ? S_PTR : S_WR_DATA;
                                end
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            drv_pend_q <= 1'b1;
                            hold_cnt_q <= HOLD;
                            if (bit_cnt_q == 4'd8) begin
                                drv_sel_q <= DRV_REL;
                                state_q   <= S_RD_ACK;
                            end else begin
                                drv_sel_q <= DRV_DATA;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ack_q <= sda_sync_q;
                        end else if (scl_fall) begin
                            if (!ack_q) begin
                                ptr_q       <= ptr_q + 8'd1;
                                req_valid_q <= 1'b1;
                                req_write_q <= 1'b0;
                                req_addr_q  <= ptr_q + 8'd1;
                                drv_pend_q  <= 1'b1;
                                hold_cnt_q  <= HOLD;
                                drv_sel_q   <= DRV_DATA;
                                bit_cnt_q   <= 4'd0;
                                state_q     <= S_RD_DATA;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda       = sda_rel_q;
    assign o_sda_dir   = sda_rel_q;
    assign o_req_valid = req_valid_q;
    assign o_req_write = req_write_q;
    assign o_req_addr  = req_addr_q;
    assign o_req_wdata = req_wdata_q;
    assign o_busy      = busy_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-level I2C master drives the bus, a
// register-bus model answers reads with addr^0xFF, and a strobe monitor
// checks every register-bus request against an expected queue.
module tb_i2c_slave_regs;

    localparam int Q = 6;
    localparam int H = 12;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_IGNORE = 4'd9;

    logic       clk = 1'b0;
    logic       nrst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_line;
    logic       o_sda;
    logic       o_sda_dir;
    logic       o_req_valid;
    logic       o_req_write;
    logic [7:0] o_req_addr;
    logic [7:0] o_req_wdata;
    logic [7:0] resp_rdata = 8'h00;
    logic       o_busy;
    logic [3:0] o_dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] exp_q[$];
    logic [16:0] mon_act;
    logic [16:0] mon_exp;
    logic        watch_drive = 1'b0;
    logic        drive_seen  = 1'b0;

    // Clock
    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target
    assign sda_line = m_sda & (o_sda_dir | o_sda);

    i2c_slave_regs #(
        .DEV_ADDR    (7'h74),
        .HOLD_CYCLES (2)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_scl        (m_scl),
        .i_sda        (sda_line),
        .o_sda        (o_sda),
        .o_sda_dir    (o_sda_dir),
        .o_req_valid  (o_req_valid),
        .o_req_write  (o_req_write),
        .o_req_addr   (o_req_addr),
        .o_req_wdata  (o_req_wdata),
        .i_resp_rdata (resp_rdata),
        .o_busy       (o_busy),
        .o_dbg_state  (o_dbg_state)
    );

    // CSR bank model: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (o_req_valid && !o_req_write) begin
            resp_rdata <= o_req_addr ^ 8'hFF;
        end
    end

    // Strobe monitor: pop expected request and compare
    always @(negedge clk) begin
        if (nrst && o_req_valid) begin
            n_tests++;
            mon_act = {o_req_write, o_req_addr, (o_req_write ? o_req_wdata : 8'h00)};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got w=%0d addr=%h data=%h, expected no strobe",
                         mon_act[16], mon_act[15:8], mon_act[7:0]);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL strobe: got w=%0d addr=%h data=%h, expected w=%0d addr=%h data=%h",
                             mon_act[16], mon_act[15:8], mon_act[7:0],
                             mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    // Flags any SDA drive while watching a transaction to another address
    always @(negedge clk) begin
        if (watch_drive && o_sda_dir == 1'b0) begin
            drive_seen = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_strobe(input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({w, a, d});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            cyc(Q);
            m_scl = 1'b1;
            cyc(H);
        end
        m_sda = 1'b0;
        cyc(H);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        cyc(Q);
        m_scl = 1'b1;
        cyc(H);
        m_sda = 1'b1;
        cyc(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        cyc(Q);
        m_scl = 1'b1;
        cyc(H);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1;
        cyc(Q);
        m_scl = 1'b1;
        cyc(Q);
        b = sda_line;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rd;

        nrst  = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        cyc(5);
        nrst = 1'b1;
        cyc(5);

        // Reset values
        check("rst_sda", o_sda, 1);
        check("rst_sda_dir", o_sda_dir, 1);
        check("rst_req_valid", o_req_valid, 0);
        check("rst_req_write", o_req_write, 0);
        check("rst_req_addr", o_req_addr, 0);
        check("rst_req_wdata", o_req_wdata, 0);
        check("rst_busy", o_busy, 0);
        check("rst_state", o_dbg_state, ST_IDLE);

        // Write two bytes at pointer 0x10
        push_strobe(1'b1, 8'h10, 8'hA5);
        push_strobe(1'b1, 8'h11, 8'h3C);
        bus_start();
        write_byte(8'hE8, ack);
        check("t1_addr_ack", ack, 0);
        check("t1_busy", o_busy, 1);
        write_byte(8'h10, ack);
        check("t1_ptr_ack", ack, 0);
        write_byte(8'hA5, ack);
        check("t1_d0_ack", ack, 0);
        write_byte(8'h3C, ack);
        check("t1_d1_ack", ack, 0);
        bus_stop();
        check("t1_busy_after_stop", o_busy, 0);
        check("t1_state_idle", o_dbg_state, ST_IDLE);

        // Pointer 0x20, repeated START, read three bytes
        push_strobe(1'b0, 8'h20, 8'h00);
        push_strobe(1'b0, 8'h21, 8'h00);
        push_strobe(1'b0, 8'h22, 8'h00);
        bus_start();
        write_byte(8'hE8, ack);
        check("t2_addr_ack", ack, 0);
        write_byte(8'h20, ack);
        check("t2_ptr_ack", ack, 0);
        bus_start();
        write_byte(8'hE9, ack);
        check("t2_raddr_ack", ack, 0);
        read_byte(1'b0, rd);
        check("t2_rd0", rd, 8'hDF);
        read_byte(1'b0, rd);
        check("t2_rd1", rd, 8'hDE);
        read_byte(1'b1, rd);
        check("t2_rd2", rd, 8'hDD);
        check("t2_busy_after_nack", o_busy, 0);
        check("t2_state_ignore", o_dbg_state, ST_IGNORE);
        bus_stop();

        // Another device's address: target stays off the bus
        drive_seen  = 1'b0;
        watch_drive = 1'b1;
        bus_start();
        write_byte(8'hA0, ack);
        check("t3_addr_nack", ack, 1);
        write_byte(8'h12, ack);
        check("t3_data_nack", ack, 1);
        check("t3_busy", o_busy, 0);
        check("t3_state_ignore", o_dbg_state, ST_IGNORE);
        bus_stop();
        watch_drive = 1'b0;
        check("t3_sda_never_driven", drive_seen, 0);

        // Pointer wrap 0xFF -> 0x00
        push_strobe(1'b1, 8'hFF, 8'h11);
        push_strobe(1'b1, 8'h00, 8'h22);
        bus_start();
        write_byte(8'hE8, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        check("t4_d0_ack", ack, 0);
        write_byte(8'h22, ack);
        check("t4_d1_ack", ack, 0);
        bus_stop();

        // STOP in the middle of a data byte
        bus_start();
        write_byte(8'hE8, ack);
        write_byte(8'h40, ack);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        bus_stop();
        check("t5_state_idle", o_dbg_state, ST_IDLE);
        check("t5_sda_released", o_sda_dir, 1);
        check("t5_busy", o_busy, 0);
        push_strobe(1'b1, 8'h40, 8'h5A);
        bus_start();
        write_byte(8'hE8, ack);
        check("t5_next_addr_ack", ack, 0);
        write_byte(8'h40, ack);
        write_byte(8'h5A, ack);
        check("t5_next_d_ack", ack, 0);
        bus_stop();

        // Reset while the target drives a 0 read bit
        push_strobe(1'b0, 8'h20, 8'h00);
        bus_start();
        write_byte(8'hE8, ack);
        write_byte(8'h20, ack);
        bus_start();
        write_byte(8'hE9, ack);
        recv_bit(b);
        check("t6_bit7", b, 1);
        recv_bit(b);
        check("t6_bit6", b, 1);
        cyc(1);
        check("t6_driving_zero", o_sda_dir, 0);
        nrst = 1'b0;
        #1;
        check("t6_rst_sda_dir", o_sda_dir, 1);
        check("t6_rst_sda", o_sda, 1);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_req_addr", o_req_addr, 0);
        check("t6_rst_req_wdata", o_req_wdata, 0);
        check("t6_rst_state", o_dbg_state, ST_IDLE);
        cyc(3);
        nrst = 1'b1;
        cyc(3);
        bus_stop();
        push_strobe(1'b0, 8'h00, 8'h00);
        bus_start();
        write_byte(8'hE9, ack);
        check("t6_post_addr_ack", ack, 0);
        read_byte(1'b1, rd);
        check("t6_post_rd", rd, 8'hFF);
        bus_stop();

        cyc(50);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
